// File: rtl/posit_pkg.sv
// rtl/posit_pkg.sv - shared helpers for the posit encoder: regime width and special-value patterns
package posit_pkg;

  localparam int MAX_BITS = 64;
  typedef logic [MAX_BITS-1:0] pword_t;

  // Control flags that travel with the stage-1 magnitude
  typedef struct packed {
    logic sign;
    logic zero;
    logic nar;
    logic sat;
  } s1_ctl_t;

  function automatic int sw_of(input int bits);
    return $clog2(bits) + 2;
  endfunction

  function automatic pword_t nar_pat(input int bits);
    return pword_t'(1) << (bits - 1);
  endfunction

  function automatic pword_t maxpos_pat(input int bits);
    return (pword_t'(1) << (bits - 1)) - pword_t'(1);
  endfunction

  function automatic pword_t minpos_pat(input int bits);
    return pword_t'(1);
  endfunction

endpackage

// File: rtl/posit_round_rne.sv
// rtl/posit_round_rne.sv - combinational round-to-nearest-even, clamp and negate of a posit magnitude
module posit_round_rne
  import posit_pkg::*;
#(
  parameter int BITS = 32
) (
  input  logic            sign,
  input  logic            zero,
  input  logic            nar,
  input  logic            sat_in,
  input  logic [BITS-2:0] mag,
  input  logic            guard,
  input  logic            sticky,
  output logic [BITS-1:0] posit,
  output logic            sat,
  output logic            round_up
);

  localparam pword_t NAR_W    = nar_pat(BITS);
  localparam pword_t MAXPOS_W = maxpos_pat(BITS);
  localparam pword_t MINPOS_W = minpos_pat(BITS);
  localparam logic [BITS-1:0] NAR    = NAR_W[BITS-1:0];
  localparam logic [BITS-1:0] MAXPOS = MAXPOS_W[BITS-1:0];
  localparam logic [BITS-1:0] MINPOS = MINPOS_W[BITS-1:0];

  logic            up;
  logic [BITS-1:0] sum;
  logic [BITS-2:0] m;
  logic [BITS-1:0] word;

  always_comb begin
    up   = guard & (mag[0] | sticky);
    sum  = {1'b0, mag} + {{(BITS-1){1'b0}}, up};
    m    = sum[BITS-2:0];
    sat  = sat_in;
    // A carry out of the magnitude would flip the sign bit, so pin to maxpos instead
    if (sum[BITS-1]) begin
      m   = MAXPOS[BITS-2:0];
      sat = 1'b1;
    end
    if (m == '0) begin
      m = MINPOS[BITS-2:0];
    end
    word     = {1'b0, m};
    posit    = sign ? (~word + {{(BITS-1){1'b0}}, 1'b1}) : word;
    round_up = up;
    if (nar) begin
      posit    = NAR;
      sat      = 1'b0;
      round_up = 1'b0;
    end else if (zero) begin
      posit    = '0;
      sat      = 1'b0;
      round_up = 1'b0;
    end
  end

endmodule

// File: rtl/posit_pack_pipe.sv
// rtl/posit_pack_pipe.sv - two-stage posit encoder (regime/shift, then round/sign) with valid/ready
// Optional PACK_STATS_EN adds round-up and saturation event counters.
module posit_pack_pipe
  import posit_pkg::*;
#(
  parameter int BITS = 32,
  parameter int ES   = 3,
  parameter int SW   = sw_of(BITS),
  parameter int EW   = (ES > 0) ? ES : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sign,
  input  logic signed [SW-1:0] in_k,
  input  logic [EW-1:0]        in_exp,
  input  logic [BITS-1:0]      in_frac,
  input  logic                 in_sticky,
  input  logic                 in_zero,
  input  logic                 in_nar,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BITS-1:0]      out_posit,
  output logic                 out_sat
`ifdef PACK_STATS_EN
  ,
  input  logic                 stat_clr,
  output logic [15:0]          stat_round_up,
  output logic [15:0]          stat_sat
`endif
);

  localparam int M  = BITS - 1;
  localparam int BW = ES + BITS;
  localparam int XW = M + 1 + BW;
  localparam pword_t MAXPOS_W = maxpos_pat(BITS);
  localparam pword_t MINPOS_W = minpos_pat(BITS);
  localparam logic [M-1:0] MAG_MAX = MAXPOS_W[M-1:0];
  localparam logic [M-1:0] MAG_MIN = MINPOS_W[M-1:0];

  typedef struct packed {
    s1_ctl_t       ctl;
    logic [M-1:0]  mag;
    logic          guard;
    logic          sticky;
  } s1_t;

  logic [BW-1:0] body;

  if (ES > 0) begin : g_exp
    assign body = {in_exp, in_frac};
  end else begin : g_noexp
    assign body = in_frac;
  end

  int            kk;
  int            cnt;
  int            sh;
  logic          pos;
  logic [XW-1:0] ext;
  logic [XW-1:0] win;
  s1_t           s1_d;

  always_comb begin
    kk  = int'(in_k);
    pos = (kk >= 0);
    cnt = pos ? kk + 1 : -kk;
    sh  = (cnt >= 1 && cnt <= M) ? M - cnt : 0;
    // Regime run is the fill, its terminator is the bit ahead of the body
    ext = {{M{pos}}, ~pos, body};
    win = ext << sh;

    s1_d.ctl.sign = in_sign;
    s1_d.ctl.zero = in_zero;
    s1_d.ctl.nar  = in_nar;
    s1_d.ctl.sat  = 1'b0;
    s1_d.mag      = win[XW-1 -: M];
    s1_d.guard    = win[BW];
    s1_d.sticky   = (|win[BW-1:0]) | in_sticky;

    if (kk >= BITS - 2) begin
      s1_d.mag     = MAG_MAX;
      s1_d.guard   = 1'b0;
      s1_d.sticky  = 1'b0;
      s1_d.ctl.sat = (kk > BITS - 2) | (|body) | in_sticky;
    end else if (kk < -(BITS - 2)) begin
      s1_d.mag     = MAG_MIN;
      s1_d.guard   = 1'b0;
      s1_d.sticky  = 1'b0;
      s1_d.ctl.sat = 1'b1;
    end
  end

  logic s1_full;
  logic s2_full;
  s1_t  s1_q;
  logic s1_open;
  logic s2_open;

  assign s2_open   = !s2_full || out_ready;
  assign s1_open   = s2_open || !s1_full;
  assign in_ready  = !rst && s1_open;
  assign out_valid = s2_full;

  logic [BITS-1:0] r_posit;
  logic            r_sat;
  logic            r_up;

  posit_round_rne #(.BITS(BITS)) u_round (
    .sign     (s1_q.ctl.sign),
    .zero     (s1_q.ctl.zero),
    .nar      (s1_q.ctl.nar),
    .sat_in   (s1_q.ctl.sat),
    .mag      (s1_q.mag),
    .guard    (s1_q.guard),
    .sticky   (s1_q.sticky),
    .posit    (r_posit),
    .sat      (r_sat),
    .round_up (r_up)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_full   <= 1'b0;
      s1_q      <= '0;
      s2_full   <= 1'b0;
      out_posit <= '0;
      out_sat   <= 1'b0;
    end else begin
      if (s1_open) begin
        s1_full <= in_valid;
        if (in_valid) s1_q <= s1_d;
      end
      if (s2_open) begin
        s2_full <= s1_full;
        if (s1_full) begin
          out_posit <= r_posit;
          out_sat   <= r_sat;
        end
      end
    end
  end

`ifdef PACK_STATS_EN
  logic out_up;
  logic out_hs;

  assign out_hs = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_up <= 1'b0;
    end else if (s2_open && s1_full) begin
      out_up <= r_up;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      stat_round_up <= '0;
      stat_sat      <= '0;
    end else if (out_hs) begin
      if (out_up && stat_round_up != 16'hFFFF) stat_round_up <= stat_round_up + 16'd1;
      if (out_sat && stat_sat != 16'hFFFF) stat_sat <= stat_sat + 16'd1;
    end
  end
`endif

endmodule
